burst_line_adaptor: RTL and testbench
=====================================

# burst_line_adaptor

Parametrised successor to the LLC-to-DRAM line adaptor: converts one cache-line read or write from the last-level cache into `BEATS = LINE_W/BURST_W` memory bursts, and reassembles read bursts into a line. Supports memory stalls between beats and latches the request address. Optionally returns the critical beat first. It sits between the LLC miss/writeback port and the DRAM controller.

## Interface
- `LINE_W`, 256, cache line width in bits
- `BURST_W`, 64, memory beat width in bits
- `ADDR_W`, 32, address width
- `clk` in 1 clock; all logic on the rising edge
- `reset_n` in 1 synchronous active-low reset
- `line_i` in LINE_W write line from LLC
- `line_o` out LINE_W read line to LLC
- `address_i` in ADDR_W byte address from LLC
- `read_i` in 1 LLC line read request, level
- `write_i` in 1 LLC line write request, level
- `resp_o` out 1 one-cycle completion pulse to LLC
- `burst_i` in BURST_W read beat from memory
- `burst_o` out BURST_W write beat to memory
- `address_o` out ADDR_W registered memory address
- `read_o` out 1 memory read request
- `write_o` out 1 memory write request
- `resp_i` in 1 memory beat strobe; one beat transfers per cycle it is high

## Operation
- Derived values:
  - `BEATS = LINE_W/BURST_W`, which must be a power of two and ≥2.
  - `OFF_LO = log2(BURST_W/8)` and `OFF_HI = log2(LINE_W/8)-1`.
  - Illegal parameters raise an elaboration-time `$error`.
- States: IDLE, RD, RD_DONE, WR, WR_DONE.
- State: 256-bit-style `buffer` (LINE_W), beat index `idx`, remaining-beat counter `left` (log2(BEATS)+1 bits).
- IDLE:
  - `read_i` alone → RD.
  - `write_i` alone → WR, and `buffer <= line_i`.
  - Both high, or neither → stay in IDLE (protocol violation is ignored).
  - On accept: `address_o <= address_i` with bits [OFF_HI:0] cleared (see Configuration), `idx <= start beat`, `left <= BEATS`.
- RD:
  - `read_o = 1`.
  - Each cycle with `resp_i = 1`: `buffer[idx*BURST_W +: BURST_W] <= burst_i`, `idx <= idx+1` (mod BEATS, wraps), `left <= left-1`.
  - When `left == 1` and `resp_i` → RD_DONE.
- RD_DONE: `resp_o = 1` and `line_o = buffer` for one cycle → IDLE.
- WR:
  - `write_o = 1` and `burst_o = buffer[idx*BURST_W +: BURST_W]`.
  - Beats advance on `resp_i` exactly as in RD.
  - Last beat → WR_DONE.
- WR_DONE: `resp_o = 1` for one cycle → IDLE.
- Outside RD_DONE, `line_o = 0`. Outside WR, `burst_o = 0`.
- `resp_i` is ignored in IDLE, RD_DONE and WR_DONE.
- The LLC holds `read_i`/`write_i` and `line_i`/`address_i` stable until `resp_o`, then deasserts in the following cycle. A request still high in the IDLE cycle after `resp_o` starts a new transaction.

## Timing
- Reset values: state IDLE, `buffer = 0`, `idx = 0`, `left = 0`, `address_o = 0`.
- All outputs are 0 after reset.
- `read_o`/`write_o` rise the cycle after the request is sampled in IDLE. They stay high through the cycle of the final `resp_i`, then drop.
- Minimum latency, request cycle to `resp_o` cycle: BEATS+1 cycles (4 beats → `resp_o` in cycle T+5). Each low-`resp_i` cycle in RD/WR adds one cycle.
- `address_o` is constant from the cycle after accept until the next accept.
- Reset asserted mid-transaction:
  - Next cycle is IDLE, all outputs are 0, and the buffer is cleared.
  - No `resp_o` is produced.
  - Memory must tolerate `read_o`/`write_o` dropping early.

## Configuration
- `BURST_LINE_ADAPTOR_WRAP_EN` defined, critical-beat-first wrapping mode:
  - Start beat = `address_i[OFF_HI:OFF_LO]`.
  - `address_o` = `address_i` with only bits [OFF_LO-1:0] cleared.
  - Beats are transferred in wrapping order start, start+1, … mod BEATS. Each beat is placed at its natural line offset.
- Undefined:
  - Start beat = 0.
  - `address_o` is line-aligned (bits [OFF_HI:0] cleared).
  - Beats are transferred in order 0..BEATS-1.

## Test plan
- Read, no stalls, default params:
  - Stimulus: `address_i = 0x1000_0040`, `read_i` held; `burst_i` = 0x11…11, 0x22…22, 0x33…33, 0x44…44 on consecutive `resp_i`.
  - Required: `address_o = 0x1000_0040`; `line_o = {0x44..,0x33..,0x22..,0x11..}` with `resp_o` high exactly one cycle, 5 cycles after request.
- Read with stalls:
  - Stimulus: `resp_i` pattern 1,0,0,1,1,0,1.
  - Required: `resp_o` in the cycle after the 7th beat-phase cycle; line correct; `read_o` low the cycle after the last beat.
- Write:
  - Stimulus: `line_i = {D3,D2,D1,D0}`, with `line_i` changed after accept.
  - Required: `burst_o` = D0, D1, D2, D3 on successive `resp_i` cycles, using the captured values; `resp_o` one cycle after the 4th beat.
- Wrap mode (macro defined):
  - Stimulus: read with `address_i = 0x0000_0058` (beat 3).
  - Required: `address_o = 0x58`; the first returned beat lands in `line_o[255:192]` and the next in `[63:0]`.
- Reset mid-read:
  - Stimulus: `reset_n = 0` after 2 beats.
  - Required: `read_o = 0` next cycle, no `resp_o`; a subsequent read completes normally.
- `read_i` and `write_i` both high for 10 cycles → required: `read_o`/`write_o` stay 0 and the state remains IDLE.

Source files
------------

// File: rtl/burst_line_adaptor.sv
// Splits an LLC line read/write into BEATS memory bursts and reassembles read beats into a line.
// Define BURST_LINE_ADAPTOR_WRAP_EN for critical-beat-first (wrapping) transfer order.
module burst_line_adaptor #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int BEATS  = LINE_W / BURST_W;
    localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_LO = $clog2(BURST_W / 8);
    localparam int OFF_HI = $clog2(LINE_W / 8) - 1;

    localparam logic [IDX_W:0]   LEFT_INIT = (IDX_W + 1)'(BEATS);
    localparam logic [IDX_W:0]   LEFT_ONE  = (IDX_W + 1)'(1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    if (BEATS < 2 || (BEATS & (BEATS - 1)) != 0 || (LINE_W % BURST_W) != 0 ||
        (BURST_W % 8) != 0 || ((BURST_W / 8) & ((BURST_W / 8) - 1)) != 0 ||
        ADDR_W <= OFF_HI + 1) begin : g_bad_params
        $error("burst_line_adaptor: illegal LINE_W/BURST_W/ADDR_W combination");
    end

    typedef enum logic [2:0] {IDLE, RD, RD_DONE, WR, WR_DONE} state_t;

`ifdef BURST_LINE_ADAPTOR_WRAP_EN
    localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W - OFF_LO){1'b1}}, {OFF_LO{1'b0}}};
    logic [IDX_W-1:0] start_beat;
    assign start_beat = address_i[OFF_HI:OFF_LO];
`else
    localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W - OFF_HI - 1){1'b1}}, {(OFF_HI + 1){1'b0}}};
    logic [IDX_W-1:0] start_beat;
    assign start_beat = '0;
`endif

    state_t                         state_q;
    logic [BEATS-1:0][BURST_W-1:0]  buffer_q;
    logic [IDX_W-1:0]               idx_q;
    logic [IDX_W:0]                 left_q;
    logic [ADDR_W-1:0]              addr_q;
    logic                           read_q;
    logic                           write_q;
    logic                           resp_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            buffer_q <= '0;
            idx_q    <= '0;
            left_q   <= '0;
            addr_q   <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            resp_q   <= 1'b0;
        end else begin
            resp_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Simultaneous read and write is a protocol violation and is ignored.
                    if (read_i ^ write_i) begin
                        addr_q <= address_i & ADDR_MASK;
                        idx_q  <= start_beat;
                        left_q <= LEFT_INIT;
                        if (read_i) begin
                            state_q <= RD;
                            read_q  <= 1'b1;
                        end else begin
                            state_q  <= WR;
                            write_q  <= 1'b1;
                            buffer_q <= line_i;
                        end
                    end
                end
                RD: begin
                    if (resp_i) begin
                        buffer_q[idx_q] <= burst_i;
                        idx_q           <= idx_q + IDX_ONE;
                        left_q          <= left_q - LEFT_ONE;
                        if (left_q == LEFT_ONE) begin
                            state_q <= RD_DONE;
                            read_q  <= 1'b0;
                            resp_q  <= 1'b1;
                        end
                    end
                end
                WR: begin
                    if (resp_i) begin
                        idx_q  <= idx_q + IDX_ONE;
                        left_q <= left_q - LEFT_ONE;
                        if (left_q == LEFT_ONE) begin
                            state_q <= WR_DONE;
                            write_q <= 1'b0;
                            resp_q  <= 1'b1;
                        end
                    end
                end
                RD_DONE, WR_DONE: state_q <= IDLE;
                default:          state_q <= IDLE;
            endcase
        end
    end

    assign address_o = addr_q;
    assign read_o    = read_q;
    assign write_o   = write_q;
    assign resp_o    = resp_q;
    assign line_o    = (state_q == RD_DONE) ? buffer_q : '0;
    assign burst_o   = (state_q == WR) ? buffer_q[idx_q] : '0;

endmodule

// File: tb/tb_burst_line_adaptor.sv
// Scoreboard bench for burst_line_adaptor: stimulus pushes expected responses, a negedge monitor checks them.
// Reference model follows BURST_LINE_ADAPTOR_WRAP_EN to pick the beat order and address alignment.
module tb_burst_line_adaptor;

    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;
    localparam int ADDR_W  = 32;
    localparam int BEATS   = LINE_W / BURST_W;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [LINE_W-1:0]  line_i = '0;
    logic [LINE_W-1:0]  line_o;
    logic [ADDR_W-1:0]  address_i = '0;
    logic               read_i = 1'b0;
    logic               write_i = 1'b0;
    logic               resp_o;
    logic [BURST_W-1:0] burst_i = '0;
    logic [BURST_W-1:0] burst_o;
    logic [ADDR_W-1:0]  address_o;
    logic               read_o;
    logic               write_o;
    logic               resp_i = 1'b0;

    burst_line_adaptor #(.LINE_W(LINE_W), .BURST_W(BURST_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .line_i(line_i), .line_o(line_o),
        .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
        .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
        .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                cyc;
        logic              is_rd;
        logic [LINE_W-1:0] line;
    } resp_t;

    resp_t              resp_sb[$];
    logic [BURST_W-1:0] burst_sb[$];
    int                 vectors = 0;
    int                 errors  = 0;
    logic               beat_phase = 1'b0;
    logic               beat_rd    = 1'b0;
    logic               chk_reset  = 1'b0;
    logic [ADDR_W-1:0]  exp_addr   = '0;

    task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic int start_of(input logic [ADDR_W-1:0] a);
`ifdef BURST_LINE_ADAPTOR_WRAP_EN
        return int'((a / (BURST_W / 8)) % BEATS);
`else
        return 0;
`endif
    endfunction

    function automatic logic [ADDR_W-1:0] align_of(input logic [ADDR_W-1:0] a);
`ifdef BURST_LINE_ADAPTOR_WRAP_EN
        return a - (a % (BURST_W / 8));
`else
        return a - (a % (LINE_W / 8));
`endif
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Monitor: every cycle checks strobes and zero-gating, pops scoreboard entries on beats/responses.
    always @(negedge clk) begin
        chk("read_o", read_o, beat_phase && beat_rd);
        chk("write_o", write_o, beat_phase && !beat_rd);
        if (!write_o) chk("burst_o_idle", burst_o, '0);
        if ((read_o || write_o) && resp_i) chk("address_o", address_o, exp_addr);
        if (write_o && resp_i) begin
            if (burst_sb.size() == 0) chk("burst_unexpected", 1, 0);
            else chk("burst_o", burst_o, burst_sb.pop_front());
        end
        if (resp_o) begin
            if (resp_sb.size() == 0) chk("resp_unexpected", 1, 0);
            else begin
                resp_t r;
                r = resp_sb.pop_front();
                chk("resp_cycle", cyc, r.cyc);
                chk("line_o", line_o, r.is_rd ? r.line : '0);
            end
        end else begin
            chk("line_o_idle", line_o, '0);
        end
        if (chk_reset) begin
            chk("reset_address_o", address_o, '0);
            chk("reset_resp_o", resp_o, 0);
        end
    end

    // pat holds the per-cycle resp_i sequence (LSB first, len cycles, exactly BEATS ones).
    task automatic run_txn(input logic is_rd, input logic [ADDR_W-1:0] addr,
                           input logic [LINE_W-1:0] data, input logic [31:0] pat,
                           input int len, input int rst_after);
        int start;
        int beat;
        int req;
        start = start_of(addr);
        @(posedge clk); #1;
        read_i    = is_rd;
        write_i   = !is_rd;
        address_i = addr;
        line_i    = data;
        resp_i    = 1'($urandom);
        req       = cyc;
        exp_addr  = align_of(addr);
        if (rst_after < 0) resp_sb.push_back('{req + len + 1, is_rd, is_rd ? data : '0});
        if (!is_rd)
            for (int k = 0; k < BEATS; k++)
                burst_sb.push_back(data[((start + k) % BEATS) * BURST_W +: BURST_W]);
        beat = 0;
        for (int c = 0; c < len; c++) begin
            @(posedge clk); #1;
            if (c == 0 && !is_rd) line_i = rand_line();
            beat_phase = 1'b1;
            beat_rd    = is_rd;
            if (rst_after >= 0 && beat == rst_after) begin
                reset_n = 1'b0;
                resp_i  = 1'b0;
                @(posedge clk); #1;
                reset_n    = 1'b1;
                read_i     = 1'b0;
                write_i    = 1'b0;
                beat_phase = 1'b0;
                chk_reset  = 1'b1;
                burst_sb.delete();
                @(posedge clk); #1;
                chk_reset = 1'b0;
                return;
            end
            resp_i = pat[c];
            if (resp_i && is_rd) begin
                burst_i = data[((start + beat) % BEATS) * BURST_W +: BURST_W];
            end else begin
                burst_i = {$urandom, $urandom};
            end
            if (resp_i) beat++;
        end
        @(posedge clk); #1;
        beat_phase = 1'b0;
        resp_i     = 1'($urandom);
        burst_i    = {$urandom, $urandom};
        @(posedge clk); #1;
        read_i  = 1'b0;
        write_i = 1'b0;
        resp_i  = 1'b0;
    endtask

    initial begin
        logic [LINE_W-1:0] seq_line;
        seq_line = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};

        @(posedge clk);
        @(posedge clk); #1;
        reset_n   = 1'b1;
        chk_reset = 1'b1;
        @(posedge clk); #1;
        chk_reset = 1'b0;

        run_txn(1'b1, 32'h1000_0040, seq_line, 32'b1111, 4, -1);
        run_txn(1'b1, $urandom, rand_line(), 32'b1011001, 7, -1);
        run_txn(1'b0, $urandom, rand_line(), 32'b1111, 4, -1);
        run_txn(1'b1, 32'h0000_0058, seq_line, 32'b1111, 4, -1);
        run_txn(1'b1, $urandom, rand_line(), 32'b1111, 4, 2);
        run_txn(1'b1, $urandom, rand_line(), 32'b1111, 4, -1);

        @(posedge clk); #1;
        read_i    = 1'b1;
        write_i   = 1'b1;
        address_i = $urandom;
        repeat (10) begin
            @(posedge clk); #1;
            resp_i = 1'($urandom);
        end
        read_i  = 1'b0;
        write_i = 1'b0;
        resp_i  = 1'b0;
        run_txn(1'b0, $urandom, rand_line(), 32'b1111, 4, -1);

        for (int t = 0; t < 60; t++) begin
            logic [31:0] pat;
            int          len;
            int          ones;
            pat  = '0;
            len  = 0;
            ones = 0;
            while (ones < BEATS) begin
                logic r;
                r = (len >= 24) ? 1'b1 : (($urandom % 3) != 0);
                pat[len] = r;
                len++;
                if (r) ones++;
            end
            run_txn(1'($urandom), $urandom, rand_line(), pat, len, -1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("resp_sb_drained", resp_sb.size(), 0);
        chk("burst_sb_drained", burst_sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
